mem_initiator: RTL
==================

// Module: mem_initiator
// PURPOSE
// Initiator (requester) side of the 16-bit read/write/resp memory handshake.
// Accepts one word or byte access at a time from a client (datapath/control)
// and drives mem_read/mem_write until the memory answers with mem_resp.
// Generates byte enables, steers byte lanes and checks word alignment.
// A watchdog aborts a request that never completes.
// PARAMETERS
// TIMEOUT_CYCLES  1024  max cycles in REQ before abort; 0 disables watchdog
// PORTS
// clk              in   1   clock; all state on rising edge
// rst_n            in   1   asynchronous, active-low reset
// req_valid        in   1   client request present
// req_ready        out  1   initiator can accept; high only in IDLE
// req_we           in   1   1 = write, 0 = read
// req_byte         in   1   1 = byte access, 0 = word access
// req_addr         in   16  byte address
// req_wdata        in   16  write data; for byte writes only [7:0] is used
// rsp_valid        out  1   one-cycle pulse: access finished
// rsp_rdata        out  16  read data; held until next rsp_valid
// rsp_error        out  1   qualifies rsp_valid: misaligned or timeout
// mem_read         out  1   memory read strobe, registered
// mem_write        out  1   memory write strobe, registered
// mem_byte_enable  out  2   [1] = high lane, [0] = low lane
// mem_address      out  16  {addr[15:1],1'b0}
// mem_wdata        out  16  write data after lane steering
// mem_resp         in   1   memory done; single-cycle pulse
// mem_rdata        in   16  memory read data, valid with mem_resp
// BEHAVIOUR
// - Reset: state IDLE, watchdog counter 0; every output 0 except req_ready=1.
// - Reset mid-access: strobes drop asynchronously. The bench keeps rst_n low
//   long enough for any memory access already in flight to finish.
// - States: IDLE, REQ, DONE.
// - IDLE: req_ready=1. On req_valid, latch the request into registers.
//   * Word access with req_addr[0]=1: go to DONE with rsp_error=1; no memory cycle.
//   * Otherwise go to REQ. mem_read/mem_write rise in the cycle after acceptance.
// - Byte enables: word access -> 2'b11. Byte access -> addr[0] ? 2'b10 : 2'b01.
// - Write data: word write -> mem_wdata = req_wdata. Byte write ->
//   mem_wdata = {req_wdata[7:0], req_wdata[7:0]}.
// - REQ: strobes, address, enables and wdata stay constant. Counter increments
//   each cycle.
//   * mem_resp sampled high: capture read data, drop strobes, go to DONE, error=0.
//     Word read -> mem_rdata. Byte read -> {8'h00, addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]}.
//     Writes leave rsp_rdata unchanged.
//   * Counter reaches TIMEOUT_CYCLES-1 with no resp: drop strobes, go to DONE, error=1.
//   * If resp and timeout occur in the same cycle, resp wins.
// - DONE: rsp_valid=1 for exactly one cycle, strobes low, req_ready=0; next state IDLE.
//   This gives at least 2 cycles with strobes low between accesses, which the
//   memory needs to pass through respond to idle.
// - mem_resp outside REQ (late or stray) is ignored and changes no state.
// - rsp_error is 0 whenever rsp_valid is 0.
// - Latency: read/write = 1 (accept) + memory wait + 1 (DONE) cycles.
//   Misaligned reject = rsp_valid 1 cycle after acceptance.
// - Only one outstanding access; no request queueing.
// TESTING
// - Word read 0x0040; memory holds 0x34 at 0x40 and 0x12 at 0x41 ->
//   mem_read=1, be=11, addr=0x0040; rsp_rdata=0x1234, rsp_error=0.
// - Byte write 0x0101, wdata 0xFFAB -> mem_write=1, be=10, addr=0x0100,
//   mem_wdata=0xABAB; read back word 0x0100 gives 0xAB??, low byte unchanged.
// - Byte read 0x0041, memory word 0x1234 -> rsp_rdata=0x0012.
//   Same read at 0x0040 -> 0x0034.
// - Word write at 0x0003 -> no mem strobe ever; rsp_valid+rsp_error one cycle
//   after accept; req_ready back to 1 the cycle after that.
// - TIMEOUT_CYCLES=16 with mem_resp tied 0 -> strobes drop after 16 REQ cycles;
//   rsp_error=1. A later mem_resp pulse in IDLE has no effect.
// - Back-to-back reads with req_valid held high -> strobes low for >=2 cycles
//   between accesses; assert rst_n low mid-REQ -> all outputs 0 immediately,
//   req_ready=1.

Source files
------------

// File: rtl/mem_initiator_if.sv
// Client request/response and memory strobe bundle for the 16-bit initiator.
// master = initiator side, slave = client + memory side.
interface mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_resp, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_byte, req_addr, req_wdata, mem_resp, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_initiator.sv
// Single-outstanding word/byte memory initiator with lane steering, alignment check and watchdog.
// Latency: accept + memory wait + 1 (misaligned: 1); backpressure: req_ready only in IDLE.
module mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_initiator_if.master bus
);
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        resp_hit;
    logic        to_abort;
    logic        misaligned;
    logic        timeout_hit;

    logic [CNT_W-1:0] cnt_q;
    logic        rd_q;
    logic        wr_q;
    logic [1:0]  be_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        byte_q;
    logic        lane_q;

    assign misaligned  = !bus.req_byte && bus.req_addr[0];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(CNT_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // mem_resp is only looked at in REQ, so late or stray pulses fall through.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        resp_hit = 1'b0;
        to_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_resp) begin
                    resp_hit = 1'b1;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    to_abort = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
            byte_q  <= 1'b0;
            lane_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            err_q <= misaligned;
            if (!misaligned) begin
                rd_q    <= !bus.req_we;
                wr_q    <= bus.req_we;
                addr_q  <= {bus.req_addr[15:1], 1'b0};
                be_q    <= bus.req_byte ? (bus.req_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                wdata_q <= bus.req_byte ? {2{bus.req_wdata[7:0]}} : bus.req_wdata;
                byte_q  <= bus.req_byte;
                lane_q  <= bus.req_addr[0];
            end
        end else if (state_q == S_REQ) begin
            cnt_q <= cnt_q + 1'b1;
            if (resp_hit) begin
                rd_q  <= 1'b0;
                wr_q  <= 1'b0;
                err_q <= 1'b0;
                if (!wr_q) begin
                    rdata_q <= byte_q ? {8'h00, (lane_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0])}
                                      : bus.mem_rdata;
                end
            end else if (to_abort) begin
                rd_q  <= 1'b0;
                wr_q  <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready       = (state_q == S_IDLE);
    assign bus.rsp_valid       = (state_q == S_DONE);
    assign bus.rsp_error       = (state_q == S_DONE) && err_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.mem_read        = rd_q;
    assign bus.mem_write       = wr_q;
    assign bus.mem_byte_enable = be_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
endmodule
